ep1_in_arbiter: RTL and testbench

EP1_IN_ARBITER -- requirements
Module: ep1_in_arbiter

---
 rtl/ep1_in_arbiter_pkg.sv | 30 +++
 rtl/ep1_in_arbiter_if.sv | 60 ++++++
 rtl/ep1_in_arbiter_rr_pick.sv | 27 ++
 rtl/ep1_in_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_ep1_in_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ep1_in_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ep1_in_arbiter_pkg
// Description : Shared constants for the EP1 IN buffer arbiter: FSM state
//               encodings, bus widths and the default commit-ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package ep1_in_arbiter_pkg;

    // 100 ms at 50 MHz
    localparam int unsigned EP1_TIMEOUT_CYC_DEFAULT = 32'd5000000;

    localparam int unsigned EP1_ADDR_W = 11;
    localparam int unsigned EP1_DATA_W = 8;

    typedef logic [2:0] ep1_state_t;

    localparam ep1_state_t ST_IDLE      = 3'd0;
    localparam ep1_state_t ST_OWN       = 3'd1;
    localparam ep1_state_t ST_COMMIT    = 3'd2;
    localparam ep1_state_t ST_WAIT_FALL = 3'd3;
    localparam ep1_state_t ST_RELEASE   = 3'd4;

    // States in which a requester holds the buffer (grant asserted)
    function automatic logic ep1_is_busy(input ep1_state_t st);
        return (st == ST_OWN) || (st == ST_COMMIT) || (st == ST_WAIT_FALL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ep1_in_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ep1_in_arbiter_if
// Description : Requester, USB-core status and EP1 IN drive signals of the
//               EP1 IN buffer arbiter. The arbiter uses the slave modport;
//               requesters / USB core / testbench use the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface ep1_in_arbiter_if;
    import ep1_in_arbiter_pkg::*;

    // requester side
    logic                  req0;
    logic                  req1;
    logic                  gnt0;
    logic                  gnt1;
    logic [EP1_ADDR_W-1:0] addr0;
    logic [EP1_ADDR_W-1:0] addr1;
    logic [EP1_DATA_W-1:0] data0;
    logic [EP1_DATA_W-1:0] data1;
    logic                  wren0;
    logic                  wren1;
    logic                  commit0;
    logic                  commit1;
    logic [EP1_ADDR_W-1:0] commit_len0;
    logic [EP1_ADDR_W-1:0] commit_len1;
    logic                  done0;
    logic                  done1;

    // USB core side
    logic                  usb_in_ready;
    logic                  usb_in_commit_ack;
    logic [EP1_ADDR_W-1:0] usb_in_addr;
    logic [EP1_DATA_W-1:0] usb_in_data;
    logic                  usb_in_wren;
    logic                  usb_in_commit;
    logic [EP1_ADDR_W-1:0] usb_in_commit_len;

    logic                  timeout_err;

    modport slave (
        input  req0, req1, addr0, addr1, data0, data1, wren0, wren1,
               commit0, commit1, commit_len0, commit_len1,
               usb_in_ready, usb_in_commit_ack,
        output gnt0, gnt1, done0, done1,
               usb_in_addr, usb_in_data, usb_in_wren, usb_in_commit,
               usb_in_commit_len, timeout_err
    );

    modport master (
        output req0, req1, addr0, addr1, data0, data1, wren0, wren1,
               commit0, commit1, commit_len0, commit_len1,
               usb_in_ready, usb_in_commit_ack,
        input  gnt0, gnt1, done0, done1,
               usb_in_addr, usb_in_data, usb_in_wren, usb_in_commit,
               usb_in_commit_len, timeout_err
    );

endinterface
`default_nettype wire

// File: rtl/ep1_in_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : ep1_rr_pick
// Description : 2-way round-robin selector. With both requests high the
//               requester that was not granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module ep1_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       pick_o,
    output logic       valid_o
);

    assign valid_o = |req_i;

    // Contention goes to the other index; otherwise the lone requester wins
    always_comb begin
        if (req_i == 2'b11) begin
            pick_o = ~last_i;
        end else begin
            pick_o = req_i[1] & ~req_i[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ep1_in_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ep1_in_arbiter
// Description : Gives one of two requesters exclusive use of the EP1 IN
//               buffer, forwards its writes to the USB core with one cycle
//               of latency, runs the commit / ack handshake with a timeout
//               and releases the buffer for the next owner.
// Revision    : 1.0 - initial release
// ============================================================================
module ep1_in_arbiter
    import ep1_in_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = EP1_TIMEOUT_CYC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    ep1_in_arbiter_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    ep1_state_t            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic                  ack_prev_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  gnt0_q, gnt0_d;
    logic                  gnt1_q, gnt1_d;
    logic                  done0_q, done0_d;
    logic                  done1_q, done1_d;
    logic [EP1_ADDR_W-1:0] addr_q, addr_d;
    logic [EP1_DATA_W-1:0] data_q, data_d;
    logic                  wren_q, wren_d;
    logic                  commit_q, commit_d;
    logic [EP1_ADDR_W-1:0] len_q, len_d;
    logic                  terr_q, terr_d;

    logic                  w_pick;
    logic                  w_pick_valid;
    logic                  w_own_req;
    logic                  w_own_wren;
    logic                  w_own_commit;
    logic [EP1_ADDR_W-1:0] w_own_addr;
    logic [EP1_DATA_W-1:0] w_own_data;
    logic [EP1_ADDR_W-1:0] w_own_len;
    logic                  w_ack_rise;
    logic                  w_ack_fall;
    logic                  w_timeout;
    logic                  w_finish;
    logic                  w_busy_d;

    ep1_rr_pick u_pick (
        .req_i   ({bus.req1, bus.req0}),
        .last_i  (last_q),
        .pick_o  (w_pick),
        .valid_o (w_pick_valid)
    );

    // Only the current owner's port is ever looked at
    assign w_own_req    = owner_q ? bus.req1        : bus.req0;
    assign w_own_wren   = owner_q ? bus.wren1       : bus.wren0;
    assign w_own_commit = owner_q ? bus.commit1     : bus.commit0;
    assign w_own_addr   = owner_q ? bus.addr1       : bus.addr0;
    assign w_own_data   = owner_q ? bus.data1       : bus.data0;
    assign w_own_len    = owner_q ? bus.commit_len1 : bus.commit_len0;

    // Edges are taken against last cycle's ack, so an ack that is already
    // high when the commit starts is not mistaken for a fresh acknowledge
    assign w_ack_rise = bus.usb_in_commit_ack & ~ack_prev_q;
    assign w_ack_fall = ~bus.usb_in_commit_ack & ack_prev_q;
    assign w_timeout  = (cnt_q == CNT_LAST);

    // State register and current owner
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Next-state logic; commit beats a req drop, a real ack fall beats timeout
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.usb_in_ready && w_pick_valid) begin
                    state_d = ST_OWN;
                    owner_d = w_pick;
                end
            end
            ST_OWN: begin
                if (w_own_commit) begin
                    state_d = ST_COMMIT;
                end else if (!w_own_req) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_COMMIT: begin
                if (w_timeout) begin
                    state_d = ST_RELEASE;
                end else if (w_ack_rise) begin
                    state_d = ST_WAIT_FALL;
                end
            end
            ST_WAIT_FALL: begin
                if (w_ack_fall || w_timeout) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values for the registered EP1 IN drive
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        wren_d   = 1'b0;
        commit_d = commit_q;
        len_d    = len_q;
        terr_d   = terr_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        w_finish = 1'b0;
        case (state_q)
            ST_IDLE: begin
            end
            ST_OWN: begin
                addr_d = w_own_addr;
                data_d = w_own_data;
                if (w_own_commit) begin
                    len_d    = w_own_len;
                    commit_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    wren_d = w_own_wren;
                end
            end
            ST_COMMIT: begin
                if (w_timeout) begin
                    commit_d = 1'b0;
                    terr_d   = 1'b1;
                    w_finish = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_FALL: begin
                if (w_ack_fall) begin
                    commit_d = 1'b0;
                    w_finish = 1'b1;
                end else if (w_timeout) begin
                    commit_d = 1'b0;
                    terr_d   = 1'b1;
                    w_finish = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                last_d = owner_q;
            end
            default: begin
                commit_d = 1'b0;
            end
        endcase
        done0_d  = w_finish & ~owner_q;
        done1_d  = w_finish & owner_q;
        // Grant follows the state being entered, so it drops on entry to release
        w_busy_d = ep1_is_busy(state_d);
        gnt0_d   = w_busy_d & ~owner_d;
        gnt1_d   = w_busy_d & owner_d;
    end

    // Output, counter and history registers
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wren_q     <= 1'b0;
            commit_q   <= 1'b0;
            len_q      <= '0;
            terr_q     <= 1'b0;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            ack_prev_q <= 1'b0;
        end else begin
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wren_q     <= wren_d;
            commit_q   <= commit_d;
            len_q      <= len_d;
            terr_q     <= terr_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            ack_prev_q <= bus.usb_in_commit_ack;
        end
    end

    assign bus.gnt0              = gnt0_q;
    assign bus.gnt1              = gnt1_q;
    assign bus.done0             = done0_q;
    assign bus.done1             = done1_q;
    assign bus.usb_in_addr       = addr_q;
    assign bus.usb_in_data       = data_q;
    assign bus.usb_in_wren       = wren_q;
    assign bus.usb_in_commit     = commit_q;
    assign bus.usb_in_commit_len = len_q;
    assign bus.timeout_err       = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_ep1_in_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ep1_in_arbiter
// Description : Self-checking bench for ep1_in_arbiter: directed vector
//               table, hand-written corner sequences and a randomized run
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ep1_in_arbiter;

    localparam int unsigned TO   = 100;
    localparam int          NV   = 14;
    localparam int          RN   = 3000;

    localparam int PH_FREE       = 0;
    localparam int PH_OWN        = 1;
    localparam int PH_AWAIT_ACK  = 2;
    localparam int PH_AWAIT_DROP = 3;
    localparam int PH_COOL       = 4;

    typedef struct packed {
        logic        req0;
        logic        req1;
        logic        ready;
        logic        ack;
        logic        wren0;
        logic        wren1;
        logic        commit0;
        logic [10:0] addr0;
        logic [7:0]  data0;
        logic [10:0] len0;
        logic [36:0] exp;  // {gnt1,gnt0,done1,done0,wren,addr,data,commit,len,terr}
    } vec_t;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   overlap = 0;
    vec_t tbl [NV];

    // reference model state
    int          m_phase;
    int          m_owner;
    int          m_last;
    int          m_deadline;
    bit          m_prev;
    bit          m_gnt [2];
    bit          m_done [2];
    bit          m_wren;
    bit          m_commit;
    bit          m_terr;
    logic [10:0] m_addr;
    logic [10:0] m_len;
    logic [7:0]  m_data;

    ep1_in_arbiter_if bus ();

    ep1_in_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.gnt0 === 1'b1 && bus.gnt1 === 1'b1) overlap++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [36:0] obs();
        return {bus.gnt1, bus.gnt0, bus.done1, bus.done0, bus.usb_in_wren,
                bus.usb_in_addr, bus.usb_in_data, bus.usb_in_commit,
                bus.usb_in_commit_len, bus.timeout_err};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_quiet();
        bus.req0 = 1'b0;  bus.req1 = 1'b0;
        bus.wren0 = 1'b0; bus.wren1 = 1'b0;
        bus.commit0 = 1'b0; bus.commit1 = 1'b0;
        bus.addr0 = '0;   bus.addr1 = 11'h7FF;
        bus.data0 = '0;   bus.data1 = 8'hEE;
        bus.commit_len0 = '0; bus.commit_len1 = 11'h3FF;
        bus.usb_in_ready = 1'b0;
        bus.usb_in_commit_ack = 1'b0;
    endtask

    task automatic do_reset();
        drive_quiet();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic model_init();
        m_phase = PH_FREE; m_owner = 0; m_last = 1; m_deadline = -1; m_prev = 1'b0;
        m_gnt = '{1'b0, 1'b0}; m_done = '{1'b0, 1'b0};
        m_wren = 1'b0; m_commit = 1'b0; m_terr = 1'b0;
        m_addr = '0; m_len = '0; m_data = '0;
    endtask

    // One clock of arbiter behaviour given the inputs held during that cycle
    task automatic model_step(input int cyc);
        bit          rq [2];
        bit          wr [2];
        bit          cm [2];
        logic [10:0] ad [2];
        logic [10:0] ln [2];
        logic [7:0]  dt [2];
        bit          rise, fall, expired, finish, busy;
        rq = '{bus.req0, bus.req1};
        wr = '{bus.wren0, bus.wren1};
        cm = '{bus.commit0, bus.commit1};
        ad = '{bus.addr0, bus.addr1};
        ln = '{bus.commit_len0, bus.commit_len1};
        dt = '{bus.data0, bus.data1};
        rise    = bus.usb_in_commit_ack && !m_prev;
        fall    = !bus.usb_in_commit_ack && m_prev;
        expired = (cyc == m_deadline);
        finish  = 1'b0;
        m_done  = '{1'b0, 1'b0};
        m_wren  = 1'b0;
        case (m_phase)
            PH_FREE: begin
                if (bus.usb_in_ready && (rq[0] || rq[1])) begin
                    if (rq[0] && rq[1]) m_owner = 1 - m_last;
                    else                m_owner = rq[0] ? 0 : 1;
                    m_phase = PH_OWN;
                end
            end
            PH_OWN: begin
                m_addr = ad[m_owner];
                m_data = dt[m_owner];
                if (cm[m_owner]) begin
                    m_len      = ln[m_owner];
                    m_commit   = 1'b1;
                    m_deadline = cyc + int'(TO);
                    m_phase    = PH_AWAIT_ACK;
                end else begin
                    m_wren = wr[m_owner];
                    if (!rq[m_owner]) m_phase = PH_COOL;
                end
            end
            PH_AWAIT_ACK: begin
                if (expired) begin
                    m_terr = 1'b1;
                    finish = 1'b1;
                end else if (rise) begin
                    m_phase = PH_AWAIT_DROP;
                end
            end
            PH_AWAIT_DROP: begin
                if (fall) begin
                    finish = 1'b1;
                end else if (expired) begin
                    m_terr = 1'b1;
                    finish = 1'b1;
                end
            end
            default: begin
                m_last  = m_owner;
                m_phase = PH_FREE;
            end
        endcase
        if (finish) begin
            m_commit = 1'b0;
            m_done[m_owner] = 1'b1;
            m_phase = PH_COOL;
        end
        m_prev = bus.usb_in_commit_ack;
        busy = (m_phase == PH_OWN) || (m_phase == PH_AWAIT_ACK) || (m_phase == PH_AWAIT_DROP);
        m_gnt[0] = busy && (m_owner == 0);
        m_gnt[1] = busy && (m_owner == 1);
    endtask

    function automatic logic [36:0] model_obs();
        return {m_gnt[1], m_gnt[0], m_done[1], m_done[0], m_wren, m_addr, m_data,
                m_commit, m_len, m_terr};
    endfunction

    initial begin
        int          n;
        int          who;
        logic [1:0]  g;

        // req0 req1 rdy ack w0 w1 c0 addr0 data0 len0 | gnt done wren addr data commit len terr
        tbl[0]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,11'h000,8'h00,11'h000,{2'b01,2'b00,1'b0,11'h000,8'h00,1'b0,11'h000,1'b0}};
        tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,11'h000,8'h0B,11'h000,{2'b01,2'b00,1'b1,11'h000,8'h0B,1'b0,11'h000,1'b0}};
        tbl[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,11'h001,8'h5A,11'h000,{2'b01,2'b00,1'b1,11'h001,8'h5A,1'b0,11'h000,1'b0}};
        tbl[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,11'h001,8'h5A,11'h002,{2'b01,2'b00,1'b0,11'h001,8'h5A,1'b1,11'h002,1'b0}};
        tbl[4]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,11'h001,8'h5A,11'h000,{2'b01,2'b00,1'b0,11'h001,8'h5A,1'b1,11'h002,1'b0}};
        tbl[5]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,11'h001,8'h5A,11'h000,{2'b01,2'b00,1'b0,11'h001,8'h5A,1'b1,11'h002,1'b0}};
        tbl[6]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,11'h001,8'h5A,11'h000,{2'b01,2'b00,1'b0,11'h001,8'h5A,1'b1,11'h002,1'b0}};
        tbl[7]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,11'h001,8'h5A,11'h000,{2'b00,2'b01,1'b0,11'h001,8'h5A,1'b0,11'h002,1'b0}};
        tbl[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,11'h000,8'h00,11'h000,{2'b00,2'b00,1'b0,11'h001,8'h5A,1'b0,11'h002,1'b0}};
        tbl[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,11'h000,8'h00,11'h000,{2'b10,2'b00,1'b0,11'h001,8'h5A,1'b0,11'h002,1'b0}};
        tbl[10] = '{1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,11'h123,8'h77,11'h000,{2'b10,2'b00,1'b1,11'h7FF,8'hEE,1'b0,11'h002,1'b0}};
        tbl[11] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,11'h123,8'h77,11'h000,{2'b00,2'b00,1'b0,11'h7FF,8'hEE,1'b0,11'h002,1'b0}};
        tbl[12] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,11'h000,8'h00,11'h000,{2'b00,2'b00,1'b0,11'h7FF,8'hEE,1'b0,11'h002,1'b0}};
        tbl[13] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,11'h000,8'h00,11'h000,{2'b01,2'b00,1'b0,11'h7FF,8'hEE,1'b0,11'h002,1'b0}};

        // ---- reset state ----
        drive_quiet();
        reset = 1'b1;
        tick();
        tick();
        check("reset_outputs", 64'(obs()), 64'd0);
        reset = 1'b0;

        // ---- directed vector table: write/commit/ack, then req1 abandon ----
        for (int i = 0; i < NV; i++) begin
            bus.req0 = tbl[i].req0;
            bus.req1 = tbl[i].req1;
            bus.usb_in_ready = tbl[i].ready;
            bus.usb_in_commit_ack = tbl[i].ack;
            bus.wren0 = tbl[i].wren0;
            bus.wren1 = tbl[i].wren1;
            bus.commit0 = tbl[i].commit0;
            bus.addr0 = tbl[i].addr0;
            bus.data0 = tbl[i].data0;
            bus.commit_len0 = tbl[i].len0;
            tick();
            check($sformatf("vec%0d", i), 64'(obs()), 64'(tbl[i].exp));
        end

        // ---- round robin with both requesting ----
        do_reset();
        bus.usb_in_ready = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            who = 2;
            for (int t = 0; t < 10 && who == 2; t++) begin
                tick();
                if (bus.gnt0) who = 0;
                else if (bus.gnt1) who = 1;
            end
            check($sformatf("rr_order%0d", k), 64'(who), 64'(k % 2));
            if (who == 1) bus.commit1 = 1'b1; else bus.commit0 = 1'b1;
            tick();
            bus.commit0 = 1'b0;
            bus.commit1 = 1'b0;
            bus.usb_in_commit_ack = 1'b1;
            tick();
            tick();
            bus.usb_in_commit_ack = 1'b0;
            n = 0;
            for (int t = 0; t < 10 && n == 0; t++) begin
                tick();
                if ((who == 1) ? bus.done1 : bus.done0) n = 1;
            end
            check($sformatf("rr_done%0d", k), 64'(n), 64'd1);
        end
        check("rr_exclusive", 64'(overlap), 64'd0);

        // ---- ack never arrives: timeout ----
        do_reset();
        bus.usb_in_ready = 1'b1;
        bus.req0 = 1'b1;
        tick();
        bus.commit0 = 1'b1;
        bus.commit_len0 = 11'h005;
        tick();
        bus.commit0 = 1'b0;
        n = 0;
        while (bus.usb_in_commit && n < 300) begin
            tick();
            n++;
        end
        check("to_cycles", 64'(n), 64'(TO));
        check("to_done0", 64'(bus.done0), 64'd1);
        check("to_err", 64'(bus.timeout_err), 64'd1);
        bus.req0 = 1'b0;
        tick();
        check("to_after", 64'({bus.gnt0, bus.done0, bus.timeout_err}), 64'(3'b001));

        // ---- not ready: no grant until ready rises ----
        do_reset();
        bus.req0 = 1'b1;
        tick();
        tick();
        tick();
        check("nordy_gnt", 64'({bus.gnt1, bus.gnt0}), 64'd0);
        bus.usb_in_ready = 1'b1;
        tick();
        check("rdy_gnt0", 64'({bus.gnt1, bus.gnt0}), 64'(2'b01));

        // ---- reset while waiting for ack to fall ----
        do_reset();
        bus.usb_in_ready = 1'b1;
        bus.req0 = 1'b1;
        tick();
        bus.commit0 = 1'b1;
        bus.commit_len0 = 11'h007;
        tick();
        bus.commit0 = 1'b0;
        bus.usb_in_commit_ack = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        bus.usb_in_commit_ack = 1'b0;
        tick();
        check("rst_mid_outputs", 64'(obs()), 64'd0);
        reset = 1'b0;
        bus.req0 = 1'b0;
        tick();
        check("rst_no_done", 64'(obs()), 64'd0);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        tick();
        g = {bus.gnt1, bus.gnt0};
        check("rst_idle_gnt0", 64'(g), 64'(2'b01));

        // ---- randomized run against the reference model ----
        do_reset();
        model_init();
        for (int c = 0; c < RN; c++) begin
            if ($urandom_range(99) < 10) bus.req0 = ~bus.req0;
            if ($urandom_range(99) < 10) bus.req1 = ~bus.req1;
            bus.usb_in_ready = ($urandom_range(9) != 0);
            bus.wren0 = 1'($urandom_range(1));
            bus.wren1 = 1'($urandom_range(1));
            bus.addr0 = 11'($urandom);
            bus.addr1 = 11'($urandom);
            bus.data0 = 8'($urandom);
            bus.data1 = 8'($urandom);
            bus.commit0 = ($urandom_range(99) < 8);
            bus.commit1 = ($urandom_range(99) < 8);
            bus.commit_len0 = 11'($urandom);
            bus.commit_len1 = 11'($urandom);
            if ($urandom_range(99) < 25) bus.usb_in_commit_ack = ~bus.usb_in_commit_ack;
            model_step(c);
            tick();
            check($sformatf("rand_c%0d", c), 64'(obs()), 64'(model_obs()));
        end
        check("gnt_exclusive", 64'(overlap), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
